// File: rtl/mul_16b_seq.sv
// Sequential 16x16 unsigned multiplier: radix-2 shift-add, one iteration per cycle,
// with valid/ready handshakes on both sides. Partial sums go through cla16.

module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carryin,
    output logic [15:0] sum,
    output logic        carryout
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  cg;

    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            pg[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        // Second-level lookahead across the four 4-bit groups
        cg[0] = carryin;
        cg[1] = gg[0] | (pg[0] & cg[0]);
        cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cg[0]);
        cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cg[0]);
        cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & cg[0]);
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
        sum      = p ^ c;
        carryout = cg[4];
    end
endmodule

module mul_16b_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_p,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [15:0] m, h, l, addend, sum;
    logic        co;
    logic [3:0]  cnt;

    assign addend = l[0] ? m : 16'h0000;

    cla16 u_cla (
        .a        (h),
        .b        (addend),
        .carryin  (1'b0),
        .sum      (sum),
        .carryout (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            m     <= '0;
            h     <= '0;
            l     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    m     <= in_a;
                    l     <= in_b;
                    h     <= '0;
                    cnt   <= '0;
                    state <= BUSY;
                end
                BUSY: begin
                    // Carryout lands in h[15] so the 32-bit product is exact
                    {h, l} <= {co, sum, l[15:1]};
                    cnt    <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign out_p     = {h, l};
endmodule

// File: tb/tb_mul_16b_seq.sv
// Directed and light random checks for the sequential 16x16 multiplier.

module tb_mul_16b_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_p;
    logic        busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mul_16b_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair and wait for out_valid; returns product, latency, busy count
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] p, output int lat, output int nbusy);
        int w;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 40) begin
            tick();
            w++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        nbusy = 0;
        while (!out_valid && lat < 40) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        p = out_p;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        checks++; if (out_p !== 32'h0) $display("FAIL reset_out_p got %h want 00000000", out_p); else passes++;
    endtask

    task automatic test_basic;
        logic [31:0] p;
        int lat, nb;
        out_ready = 1'b1;
        run_op(16'h0003, 16'h0005, p, lat, nb);
        checks++; if (p !== 32'h0000000F) $display("FAIL basic_product got %h want 0000000f", p); else passes++;
        checks++; if (lat !== 16) $display("FAIL basic_latency got %0d want 16", lat); else passes++;
        checks++; if (nb !== 16) $display("FAIL basic_busy_cycles got %0d want 16", nb); else passes++;
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_flags got in_ready=%b busy=%b want 0 0", in_ready, busy); else passes++;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL basic_back_idle got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); else passes++;
    endtask

    task automatic test_corners;
        logic [15:0] va [4] = '{16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF};
        logic [15:0] vb [4] = '{16'hFFFF, 16'hBEEF, 16'h0002, 16'h0001};
        logic [31:0] ve [4] = '{32'hFFFE0001, 32'h00000000, 32'h00010000, 32'h0000FFFF};
        logic [31:0] p;
        int lat, nb;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], p, lat, nb);
            checks++; if (p !== ve[i]) $display("FAIL corner%0d_product got %h want %h", i, p, ve[i]); else passes++;
            checks++; if (lat !== 16) $display("FAIL corner%0d_latency got %0d want 16", i, lat); else passes++;
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] p;
        int lat, nb;
        out_ready = 1'b0;
        run_op(16'h00FF, 16'h0101, p, lat, nb);
        checks++; if (p !== 32'h0000FFFF) $display("FAIL bp_product got %h want 0000ffff", p); else passes++;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a = 16'(i * 7 + 1);
            in_b = 16'(i * 3 + 2);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_p !== 32'h0000FFFF || in_ready !== 1'b0)
                $display("FAIL bp_hold%0d got out_valid=%b out_p=%h in_ready=%b want 1 0000ffff 0", i, out_valid, out_p, in_ready);
            else passes++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); else passes++;
    endtask

    task automatic test_ignore_inputs;
        out_ready = 1'b0;
        in_a = 16'h1234;
        in_b = 16'h5678;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            tick();
        end
        checks++; if (out_valid !== 1'b1) $display("FAIL ignore_valid got %b want 1", out_valid); else passes++;
        checks++; if (out_p !== 32'h06260060) $display("FAIL ignore_product got %h want 06260060", out_p); else passes++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_abort;
        logic [31:0] p;
        int lat, nb, seen;
        out_ready = 1'b1;
        in_a = 16'h1234;
        in_b = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_p !== 32'h0)
            $display("FAIL abort_state got in_ready=%b busy=%b out_valid=%b out_p=%h want 1 0 0 00000000", in_ready, busy, out_valid, out_p);
        else passes++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen++;
            tick();
        end
        checks++; if (seen !== 0) $display("FAIL abort_no_result got %0d valid cycles want 0", seen); else passes++;
        run_op(16'h1234, 16'h5678, p, lat, nb);
        checks++; if (p !== 32'h06260060) $display("FAIL abort_rerun got %h want 06260060", p); else passes++;
        checks++; if (lat !== 16) $display("FAIL abort_rerun_latency got %0d want 16", lat); else passes++;
        tick();
        // Reset while holding a result in DONE
        out_ready = 1'b0;
        run_op(16'h0002, 16'h0003, p, lat, nb);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== 32'h0)
            $display("FAIL abort_done got out_valid=%b in_ready=%b out_p=%h want 0 1 00000000", out_valid, in_ready, out_p);
        else passes++;
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] va [3] = '{16'h0003, 16'h00FF, 16'hABCD};
        logic [15:0] vb [3] = '{16'h0005, 16'h00FF, 16'h0010};
        logic [31:0] ve [3] = '{32'h0000000F, 32'h0000FE01, 32'h000ABCD0};
        int acc [3];
        int cyc, idx, nres;
        logic took;
        out_ready = 1'b1;
        in_a = va[0];
        in_b = vb[0];
        in_valid = 1'b1;
        cyc = 0; idx = 0; nres = 0;
        while (cyc < 100 && nres < 3) begin
            took = 1'b0;
            if (in_ready && idx < 3) begin
                acc[idx] = cyc;
                took = 1'b1;
            end
            if (out_valid) begin
                checks++;
                if (nres >= idx || out_p !== ve[nres]) $display("FAIL b2b_result%0d got %h want %h", nres, out_p, ve[nres]);
                else passes++;
                nres++;
            end
            tick();
            cyc++;
            if (took) begin
                idx++;
                if (idx < 3) begin
                    in_a = va[idx];
                    in_b = vb[idx];
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++; if (nres !== 3) $display("FAIL b2b_count got %0d want 3", nres); else passes++;
        checks++; if (acc[1] - acc[0] !== 18) $display("FAIL b2b_spacing01 got %0d want 18", acc[1] - acc[0]); else passes++;
        checks++; if (acc[2] - acc[1] !== 18) $display("FAIL b2b_spacing12 got %0d want 18", acc[2] - acc[1]); else passes++;
        tick();
    endtask

    task automatic test_random;
        logic [15:0] a, b;
        logic [31:0] p, ref_p;
        int lat, nb, stall;
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            ref_p = {16'h0, a} * {16'h0, b};
            out_ready = 1'b0;
            run_op(a, b, p, lat, nb);
            checks++; if (p !== ref_p || lat !== 16) $display("FAIL rand%0d got %h lat %0d want %h lat 16", i, p, lat, ref_p); else passes++;
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) tick();
            checks++; if (out_valid !== 1'b1 || out_p !== ref_p) $display("FAIL rand%0d_stall got valid=%b p=%h want 1 %h", i, out_valid, out_p, ref_p); else passes++;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rand%0d_dup got out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready); else passes++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_ignore_inputs();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
